// File: rtl/sdram_memtest_pkg.sv
// Shared types, constants and data-pattern helpers for the SDRAM memory tester.
package sdram_memtest_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FIN   = 3'd4
  } state_e;

  // Galois LFSR for x^16+x^14+x^13+x^11+1, shifting right.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_POLY = 16'hB400;

  function automatic logic [15:0] addr_pattern(input logic [21:0] a);
    return a[15:0] ^ {10'b0, a[21:16]};
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/sdram_memtest_lfsr.sv
// 16-bit pattern generator with load-to-seed and step; only built when SDRAM_MEMTEST_LFSR_EN is defined.
`ifdef SDRAM_MEMTEST_LFSR_EN
module sdram_memtest_lfsr
  import sdram_memtest_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_i,
  input  logic        step_i,
  output logic [15:0] value_o
);

  logic [15:0] value_q;

  // Generator state: load has priority over step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      value_q <= LFSR_SEED;
    end else if (load_i) begin
      value_q <= LFSR_SEED;
    end else if (step_i) begin
      value_q <= lfsr_step(value_q);
    end else begin
      value_q <= value_q;
    end
  end

  assign value_o = value_q;

endmodule
`endif

// File: rtl/sdram_memtest.sv
// SDRAM memory tester: writes a pattern over 0..LAST_ADDR, reads it back with bounded
// outstanding reads and counts mismatches. Define SDRAM_MEMTEST_LFSR_EN for an LFSR pattern.
module sdram_memtest
  import sdram_memtest_pkg::*;
#(
  parameter int                ADDR_W      = 22,
  parameter int                DATA_W      = 16,
  parameter logic [ADDR_W-1:0] LAST_ADDR   = 22'h3FFFFF,
  parameter int                MAX_RD_PEND = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [ADDR_W-1:0] az_addr,
  output logic [1:0]        az_be_n,
  output logic [DATA_W-1:0] az_data,
  output logic              az_rd_n,
  output logic              az_wr_n,
  input  logic [DATA_W-1:0] za_data,
  input  logic              za_valid,
  input  logic              za_waitrequest
);

  localparam logic [2:0] MAX_PEND_C = 3'(MAX_RD_PEND);

  state_e            state_q;
  logic              busy_q, done_q, pass_q, az_rd_n_q, az_wr_n_q;
  logic [15:0]       err_count_q;
  logic [ADDR_W-1:0] first_err_q, az_addr_q, chk_addr_q;
  logic [DATA_W-1:0] az_data_q;
  logic [2:0]        pending_q, pending_d;

  logic              wr_acc_s, rd_acc_s, vld_s, miss_s, last_wr_s;
  logic [ADDR_W-1:0] addr_inc_s;
  logic [DATA_W-1:0] seed_data_s, next_data_s, exp_data_s;

  assign wr_acc_s   = ~az_wr_n_q & ~za_waitrequest;
  assign rd_acc_s   = ~az_rd_n_q & ~za_waitrequest;
  assign vld_s      = za_valid & (pending_q != 3'd0);
  assign miss_s     = vld_s & (za_data != exp_data_s);
  assign last_wr_s  = wr_acc_s & (az_addr_q == LAST_ADDR);
  assign addr_inc_s = az_addr_q + ADDR_W'(1);
  assign pending_d  = pending_q + {2'b00, rd_acc_s} - {2'b00, vld_s};

`ifdef SDRAM_MEMTEST_LFSR_EN
  logic [15:0] wr_lfsr_s, chk_lfsr_s;

  sdram_memtest_lfsr u_wr_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  ((state_q == ST_IDLE) & start),
    .step_i  (wr_acc_s),
    .value_o (wr_lfsr_s)
  );

  // The check generator restarts from the seed as the read pass begins.
  sdram_memtest_lfsr u_chk_lfsr (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (last_wr_s),
    .step_i  (vld_s),
    .value_o (chk_lfsr_s)
  );

  assign seed_data_s = DATA_W'(LFSR_SEED);
  assign next_data_s = DATA_W'(lfsr_step(wr_lfsr_s));
  assign exp_data_s  = DATA_W'(chk_lfsr_s);
`else
  assign seed_data_s = DATA_W'(addr_pattern(22'd0));
  assign next_data_s = DATA_W'(addr_pattern(22'(addr_inc_s)));
  assign exp_data_s  = DATA_W'(addr_pattern(22'(chk_addr_q)));
`endif

  // Sequencer, registered controller commands and result bookkeeping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      err_count_q <= 16'd0;
      first_err_q <= '0;
      az_addr_q   <= '0;
      az_data_q   <= '0;
      az_rd_n_q   <= 1'b1;
      az_wr_n_q   <= 1'b1;
      chk_addr_q  <= '0;
      pending_q   <= 3'd0;
    end else begin
      pending_q <= pending_d;
      if (vld_s) begin
        chk_addr_q <= (chk_addr_q == LAST_ADDR) ? '0 : chk_addr_q + ADDR_W'(1);
        if (miss_s) begin
          if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
          if (err_count_q == 16'd0) first_err_q <= chk_addr_q;
        end
      end
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_WRITE;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_count_q <= 16'd0;
            first_err_q <= '0;
            chk_addr_q  <= '0;
            az_addr_q   <= '0;
            az_data_q   <= seed_data_s;
            az_wr_n_q   <= 1'b0;
          end
        end
        ST_WRITE: begin
          if (last_wr_s) begin
            state_q    <= ST_READ;
            az_wr_n_q  <= 1'b1;
            az_rd_n_q  <= 1'b0;
            az_addr_q  <= '0;
            chk_addr_q <= '0;
          end else if (wr_acc_s) begin
            az_addr_q <= addr_inc_s;
            az_data_q <= next_data_s;
          end
        end
        ST_READ: begin
          if (rd_acc_s && (az_addr_q == LAST_ADDR)) begin
            state_q   <= ST_DRAIN;
            az_rd_n_q <= 1'b1;
          end else begin
            if (rd_acc_s) az_addr_q <= addr_inc_s;
            // A stalled read stays asserted; otherwise re-issue only with room in flight.
            az_rd_n_q <= (az_rd_n_q || rd_acc_s) ? (pending_d >= MAX_PEND_C) : 1'b0;
          end
        end
        ST_DRAIN: begin
          if (pending_q == 3'd0) begin
            state_q <= ST_FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_q == 16'd0);
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_count_q;
  assign first_err_addr = first_err_q;
  assign az_addr        = az_addr_q;
  assign az_be_n        = 2'b00;
  assign az_data        = az_data_q;
  assign az_rd_n        = az_rd_n_q;
  assign az_wr_n        = az_wr_n_q;

endmodule

// File: tb/tb_sdram_memtest.sv
// Bench for sdram_memtest: a 16-word instance against a controller model with 3-cycle read
// latency, plus a 64K-word instance returning all-corrupt data to exercise saturation.
`timescale 1ns/1ps
module tb_sdram_memtest;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        start1, busy1, done1, pass1, rd_n1, wr_n1, valid1, wait1;
  logic [15:0] err1, wdata1, rdata1;
  logic [21:0] ferr1, addr1;
  logic [1:0]  be1;
  logic        start2, busy2, done2, pass2, rd_n2, wr_n2, valid2, wait2;
  logic [15:0] err2, wdata2, rdata2;
  logic [21:0] ferr2, addr2;
  logic [1:0]  be2;

  sdram_memtest #(.ADDR_W(22), .DATA_W(16), .LAST_ADDR(22'd15), .MAX_RD_PEND(4)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_err_addr(ferr1), .az_addr(addr1), .az_be_n(be1), .az_data(wdata1),
    .az_rd_n(rd_n1), .az_wr_n(wr_n1), .za_data(rdata1), .za_valid(valid1), .za_waitrequest(wait1));

  sdram_memtest #(.ADDR_W(22), .DATA_W(16), .LAST_ADDR(22'h00FFFF), .MAX_RD_PEND(4)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_err_addr(ferr2), .az_addr(addr2), .az_be_n(be2), .az_data(wdata2),
    .az_rd_n(rd_n2), .az_wr_n(wr_n2), .za_data(rdata2), .za_valid(valid2), .za_waitrequest(wait2));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Reference pattern per word index, derived from the pattern rule.
  logic [15:0] pat [0:65535];
  logic [15:0] mem1 [0:15];
  logic [15:0] cmask [0:15];
  logic [15:0] mem2 [0:65535];

  int  cyc = 0;
  int  wr_cnt, rd_cnt, wr_bad, rd_bad, hold_bad, pend, max_pend, rd4_bad, stall_seen;
  int  wr_stall_at = -1, wr_stall_left = 0, vld_stall_len = 0, vld_stall_left = 0;
  bit  rand_wait = 1'b0, stray_req = 1'b0;
  int  rq_addr[$], rq_ready[$];
  int  wr_cnt2 = 0, rd_cnt2 = 0;

  // Controller model for dut1: write memory, in-order reads with 3-cycle latency, stall knobs.
  initial begin
    int a;
    bit prev_wait;
    logic [21:0] prev_addr;
    logic [15:0] prev_data;
    prev_wait = 1'b0; prev_addr = '0; prev_data = '0;
    wait1 = 1'b0; valid1 = 1'b0; rdata1 = 16'h0000; pend = 0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rq_addr.delete(); rq_ready.delete();
        pend = 0; prev_wait = 1'b0; wr_stall_left = 0; vld_stall_left = 0;
        wait1 = 1'b0; valid1 = 1'b0;
      end else begin
        if (prev_wait && (wr_n1 !== 1'b0 || addr1 !== prev_addr || wdata1 !== prev_data)) hold_bad++;
        if (!wr_n1 && wait1 && addr1 == 22'd3) stall_seen++;
        prev_wait = !wr_n1 && wait1; prev_addr = addr1; prev_data = wdata1;
        if (pend >= 4 && !rd_n1) rd4_bad++;
        if (pend > max_pend) max_pend = pend;
        if (!wr_n1 && !wait1) begin
          if (int'(addr1) != wr_cnt || wdata1 !== pat[addr1[15:0]]) wr_bad++;
          mem1[addr1[3:0]] = wdata1;
          wr_cnt++;
          if (int'(addr1) == wr_stall_at - 1) wr_stall_left = 7;
        end
        if (!rd_n1 && !wait1) begin
          if (int'(addr1) != rd_cnt) rd_bad++;
          rd_cnt++; pend++;
          rq_addr.push_back(int'(addr1)); rq_ready.push_back(cyc + 4);
          if (vld_stall_len > 0) begin vld_stall_left = vld_stall_len; vld_stall_len = 0; end
        end
        if (valid1 && pend > 0) pend--;
      end
      @(posedge clk); cyc++; #1;
      if (stray_req) begin
        valid1 = 1'b1; rdata1 = 16'hDEAD; stray_req = 1'b0;
      end else if (vld_stall_left > 0) begin
        valid1 = 1'b0; vld_stall_left--;
      end else if (rq_ready.size() > 0 && rq_ready[0] <= cyc + 1) begin
        a = rq_addr.pop_front(); void'(rq_ready.pop_front());
        valid1 = 1'b1; rdata1 = mem1[a[3:0]] ^ cmask[a[3:0]];
      end else begin
        valid1 = 1'b0;
      end
      if (wr_stall_left > 0) begin wait1 = 1'b1; wr_stall_left--; end
      else wait1 = rand_wait ? ($urandom_range(0, 3) == 0) : 1'b0;
    end
  end

  // Controller model for dut2: no stalls, 3-cycle latency, every word returned inverted.
  initial begin
    logic acc_v;
    logic [15:0] acc_d;
    logic pv [0:1];
    logic [15:0] pd [0:1];
    wait2 = 1'b0; valid2 = 1'b0; rdata2 = 16'h0000;
    pv[0] = 1'b0; pv[1] = 1'b0; pd[0] = 16'h0000; pd[1] = 16'h0000;
    forever begin
      @(negedge clk);
      acc_v = 1'b0; acc_d = 16'h0000;
      if (reset_n) begin
        if (!wr_n2) begin mem2[addr2[15:0]] = wdata2; wr_cnt2++; end
        if (!rd_n2) begin acc_v = 1'b1; acc_d = mem2[addr2[15:0]] ^ 16'hFFFF; rd_cnt2++; end
      end
      @(posedge clk); #1;
      valid2 = pv[1]; rdata2 = pd[1];
      pv[1] = pv[0]; pd[1] = pd[0]; pv[0] = acc_v; pd[0] = acc_d;
    end
  end

  task automatic rst_checks(input string tag);
    chk({tag, ":busy"}, busy1, 0);      chk({tag, ":done"}, done1, 0);
    chk({tag, ":pass"}, pass1, 0);      chk({tag, ":err_count"}, err1, 0);
    chk({tag, ":first_err"}, ferr1, 0); chk({tag, ":rd_n"}, rd_n1, 1);
    chk({tag, ":wr_n"}, wr_n1, 1);      chk({tag, ":addr"}, addr1, 0);
    chk({tag, ":data"}, wdata1, 0);     chk({tag, ":be_n"}, be1, 0);
  endtask

  task automatic clear_mask();
    for (int i = 0; i < 16; i++) cmask[i] = 16'h0000;
  endtask

  // One full test on dut1; expectations follow from the corruption mask alone.
  task automatic run1(input string tag, input int poke);
    int exp_err, exp_first, t;
    exp_err = 0; exp_first = 0;
    for (int i = 15; i >= 0; i--) if (cmask[i] != 16'h0000) begin exp_err++; exp_first = i; end
    wr_cnt = 0; rd_cnt = 0; wr_bad = 0; rd_bad = 0; hold_bad = 0;
    max_pend = 0; rd4_bad = 0; stall_seen = 0;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    chk({tag, ":busy_start"}, busy1, 1);
    chk({tag, ":done_start"}, done1, 0);
    if (poke > 0) begin
      repeat (poke) @(negedge clk);
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
    end
    t = 0;
    while (!done1 && t < 2000) begin @(negedge clk); t++; end
    chk({tag, ":done"}, done1, 1);
    chk({tag, ":busy_end"}, busy1, 0);
    chk({tag, ":pass"}, pass1, exp_err == 0);
    chk({tag, ":err_count"}, err1, exp_err);
    chk({tag, ":first_err"}, ferr1, exp_first);
    chk({tag, ":writes"}, wr_cnt, 16);
    chk({tag, ":reads"}, rd_cnt, 16);
    chk({tag, ":wr_data"}, wr_bad, 0);
    chk({tag, ":rd_order"}, rd_bad, 0);
    chk({tag, ":hold"}, hold_bad, 0);
    chk({tag, ":rd_gate"}, rd4_bad, 0);
    chk({tag, ":pend_le4"}, max_pend <= 4, 1);
  endtask

  initial begin
    int t;
    logic [15:0] s;
`ifdef SDRAM_MEMTEST_LFSR_EN
    s = 16'hACE1;
    for (int i = 0; i < 65536; i++) begin
      pat[i] = s;
      s = s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    end
`else
    s = 16'h0000;
    for (int i = 0; i < 65536; i++) pat[i] = i[15:0] ^ {10'b0, 6'(i >> 16)} ^ s;
`endif
    clear_mask();
    start1 = 1'b0; start2 = 1'b0;
    reset_n = 1'b1;
    #3 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_checks("reset");
    chk("reset2:err_count", err2, 0);
    chk("reset2:busy", busy2, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run1("clean", 0);

    cmask[5] = 16'h0001;
    run1("corrupt5", 0);
    clear_mask();

    wr_stall_at = 3;
    run1("wr_stall", 0);
    chk("wr_stall:stall_cycles", stall_seen, 7);
    wr_stall_at = -1;

    vld_stall_len = 20;
    run1("vld_stall", 0);
    chk("vld_stall:max_pend", max_pend, 4);

    // Abandon a test mid-read, then release with a stray read-valid.
    cmask[2] = 16'h0100;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    t = 0;
    while (err1 == 16'd0 && t < 500) begin @(negedge clk); t++; end
    chk("midrst:err_before", err1, 1);
    chk("midrst:in_read", rd_n1 == 1'b0 || busy1 == 1'b1, 1);
    reset_n = 1'b0; #1;
    rst_checks("midrst");
    repeat (2) @(negedge clk);
    reset_n = 1'b1; stray_req = 1'b1;
    repeat (6) @(negedge clk);
    chk("stray:err_count", err1, 0);
    chk("stray:busy", busy1, 0);
    chk("stray:done", done1, 0);
    clear_mask();
    run1("after_rst", 0);

    for (int r = 0; r < 4; r++) begin
      rand_wait = 1'b1;
      for (int i = 0; i < 16; i++)
        cmask[i] = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(1, 65535)) : 16'h0000;
      run1($sformatf("rand%0d", r), (r % 2 == 0) ? int'($urandom_range(1, 10)) : 0);
    end
    rand_wait = 1'b0;
    clear_mask();

    @(negedge clk); start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    t = 0;
    while (!done2 && t < 300000) begin @(negedge clk); t++; end
    chk("sat:done", done2, 1);
    chk("sat:err_count", err2, 16'hFFFF);
    chk("sat:pass", pass2, 0);
    chk("sat:first_err", ferr2, 0);
    chk("sat:writes", wr_cnt2, 65536);
    chk("sat:reads", rd_cnt2, 65536);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
